// File: rtl/memory_stage_wb_pipe.sv
// rtl/memory_stage_wb_pipe.sv - RV32 MEM stage with byte-writable data memory, wait-state stall FSM and MEM/WB register
// Optional misaligned-access trapping: define MEMSTAGE_ALIGN_CHECK_EN.
module memory_stage_wb_pipe #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic              FlushM,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] RD_W,
  output logic [XLEN-1:0]   ResultW,
  output logic              ValidW,
  output logic              MisalignW
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]       idx;
  logic [1:0]          ofs;
  logic                mem_op, acc_byte, acc_half, acc_word, misalign;
  logic                stall, commit, we;
  logic [XLEN-1:0]     rword, load_data, result_m, wdata;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [3:0]          wmask;

  logic                valid_q, valid_d, regwrite_q, regwrite_d, misalign_q, misalign_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;

  assign idx    = ALU_ResultM[AW+1:2];
  assign ofs    = ALU_ResultM[1:0];
  assign mem_op = MemReadM | MemWriteM;

  // Access size follows the store decode whenever the op writes, else the load decode.
  assign acc_byte = MemWriteM ? (Funct3M == 3'b000) : (Funct3M[1:0] == 2'b00);
  assign acc_half = MemWriteM ? (Funct3M == 3'b001) : (Funct3M[1:0] == 2'b01);
  assign acc_word = ~acc_byte & ~acc_half;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
  assign misalign = mem_op & ((acc_half & ofs[0]) | (acc_word & (ofs != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign rword = mem[idx];
  assign rbyte = rword[8*ofs +: 8];
  assign rhalf = ofs[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    case (Funct3M)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_data = {24'd0, rbyte};
      3'b101:  load_data = {16'd0, rhalf};
      default: load_data = rword;
    endcase
  end

  always_comb begin
    case (ResultSrcM)
      2'b01:   result_m = load_data;
      2'b10:   result_m = PCPlus4M;
      default: result_m = ALU_ResultM;
    endcase
  end

  always_comb begin
    wmask = 4'b1111;
    wdata = WriteDataM;
    if (acc_byte) begin
      wmask = 4'b0001 << ofs;
      wdata = {4{WriteDataM[7:0]}};
    end else if (acc_half) begin
      wmask = ofs[1] ? 4'b1100 : 4'b0011;
      wdata = {2{WriteDataM[15:0]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (FlushM) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op && !misalign && (WAIT_STATES > 0)) begin
            stall   = 1'b1;
            cnt_d   = 3'(WAIT_STATES);
            state_d = WAIT;
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_d != 3'd0) stall = 1'b1;
          else               state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset gates the combinational handshake so a stall cannot outlive rst.
  assign StallM = stall & ~rst;
  assign commit = ~stall & ~FlushM & ~rst;
  assign we     = commit & MemWriteM & ~misalign;

  always_comb begin
    valid_d    = commit;
    regwrite_d = commit & RegWriteM & (RD_M != '0) & ~misalign;
    rd_d       = commit ? RD_M : '0;
    result_d   = (commit & ~misalign) ? result_m : '0;
    misalign_d = commit & misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign RegWriteW = regwrite_q;
  assign RD_W      = rd_q;
  assign ResultW   = result_q;
  assign ValidW    = valid_q;
  assign MisalignW = misalign_q;
endmodule

// File: tb/tb_memory_stage_wb_pipe.sv
// tb/tb_memory_stage_wb_pipe.sv - randomized and directed checks of memory_stage_wb_pipe against a byte-array model
module tb_memory_stage_wb_pipe;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int DEPTH = 64;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0, rst = 1'b1;
  logic        RegWriteM = 0, MemWriteM = 0, MemReadM = 0, FlushM = 0;
  logic [1:0]  ResultSrcM = 0;
  logic [2:0]  Funct3M = 0;
  logic [4:0]  RD_M = 0;
  logic [31:0] PCPlus4M = 0, WriteDataM = 0, ALU_ResultM = 0;

  logic        s2, rw2, v2, m2, s0, rw0, v0, m0;
  logic [4:0]  rd2, rd0;
  logic [31:0] res2, res0;

  logic [7:0]  ref_mem [NBYTES];
  int          checks = 0, errors = 0;
  bit          dut0_ok = 1'b1;

  always #5 clk = ~clk;

  memory_stage_wb_pipe #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .REG_AW(5)) dut2 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .FlushM(FlushM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(s2), .RegWriteW(rw2), .RD_W(rd2),
    .ResultW(res2), .ValidW(v2), .MisalignW(m2));

  memory_stage_wb_pipe #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .REG_AW(5)) dut0 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .FlushM(FlushM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(s0), .RegWriteW(rw0), .RD_W(rd0),
    .ResultW(res0), .ValidW(v0), .MisalignW(m0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input logic mr, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] wd, input logic [31:0] alu);
    RegWriteM = rw; MemWriteM = mw; MemReadM = mr; ResultSrcM = rs;
    Funct3M = f3; RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  // Called at a negedge; returns at the negedge after the instruction has reached W.
  task automatic issue(input logic rw, input logic mw, input logic mr, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] wd, input logic [31:0] alu);
    int lsize, asize, ns;
    logic mis, exp_rw;
    logic [31:0] lv, exp_res, lbase, sbase;
    drive(rw, mw, mr, rs, f3, rd, pc, wd, alu);
    lsize = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    asize = mw ? ((f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4) : lsize;
    mis   = ALIGN && (mw || mr) && ((alu % asize) != 0);
    lbase = (alu & ~(lsize - 1)) % NBYTES;
    sbase = (alu & ~(asize - 1)) % NBYTES;
    lv = 0;
    for (int i = 0; i < lsize; i++) lv = lv + (32'(ref_mem[lbase + i]) << (8 * i));
    if (lsize < 4 && !f3[2] && lv[8*lsize-1]) lv = lv - (32'd1 << (8 * lsize));
    exp_res = mis ? 0 : (rs == 2'd1) ? lv : (rs == 2'd2) ? pc : alu;
    exp_rw  = rw && (rd != 0) && !mis;
    ns      = ((mw || mr) && !mis) ? 2 : 0;
    for (int k = 0; k <= ns; k++) begin
      #1;
      chk("stall", s2, (k < ns));
      @(posedge clk); #1;
      if (k < ns) chk("bubble", {v2, rw2, m2, rd2, res2}, 0);
      if (k == 0 && dut0_ok) chk("ws0_w", {s0, v0, rw0, m0, rd0, res0}, {1'b0, 1'b1, exp_rw, mis, rd, exp_res});
      @(negedge clk);
    end
    chk("valid", v2, 1'b1);
    chk("regwrite", rw2, exp_rw);
    chk("rd", rd2, rd);
    chk("result", res2, exp_res);
    chk("misalign", m2, mis);
    if (mw && !mis)
      for (int i = 0; i < asize; i++) ref_mem[sbase + i] = wd[8*i +: 8];
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {s2, v2, rw2, m2, rd2, res2, s0, v0, rw0, m0}, 0);
    chk({tag, "_0"}, {rd0, res0}, 0);
  endtask

  initial begin
    logic [31:0] old;
    drive(1, 1, 0, 0, 3'd2, 7, 0, 32'hdead, 32'h40);
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_all_zero("post_reset");
    issue(1, 0, 0, 2'd0, 3'd0, 5, 32'h4, 0, 32'h1234);
    chk("alu_op", {rw2, rd2, res2, v2}, {1'b1, 5'd5, 32'h1234, 1'b1});

    for (int w = 0; w < DEPTH; w++) issue(0, 1, 0, 0, 3'd2, 0, 0, $urandom, 32'(4 * w));

    issue(0, 1, 0, 0, 3'd2, 0, 0, 32'h80FF7F01, 32'h10);
    issue(1, 0, 1, 1, 3'b000, 3, 0, 0, 32'h11); chk("lb_11", res2, 32'h0000007F);
    issue(1, 0, 1, 1, 3'b000, 3, 0, 0, 32'h13); chk("lb_13", res2, 32'hFFFFFF80);
    issue(1, 0, 1, 1, 3'b100, 3, 0, 0, 32'h13); chk("lbu_13", res2, 32'h00000080);
    issue(1, 0, 1, 1, 3'b001, 3, 0, 0, 32'h12); chk("lh_12", res2, 32'hFFFF80FF);
    issue(1, 0, 1, 1, 3'b101, 3, 0, 0, 32'h10); chk("lhu_10", res2, 32'h00007F01);

    issue(0, 1, 0, 0, 3'd2, 0, 0, 32'h11223344, 32'h20);
    issue(0, 1, 0, 0, 3'd0, 0, 0, 32'h000000AB, 32'h21);
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h20); chk("sb_merge", res2, 32'h1122AB44);
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h20 + 4 * DEPTH); chk("alias", res2, 32'h1122AB44);
    issue(1, 1, 1, 1, 3'd2, 9, 0, 32'h55667788, 32'h24);
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h24); chk("rmw_store", res2, 32'h55667788);

    issue(1, 1, 0, 1, 3'd2, 4, 0, 32'hCAFEF00D, 32'h22);
    if (ALIGN) chk("mis_sw", {m2, rw2}, 2'b10);
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h20);
    chk("after_sw22", res2, ALIGN ? 32'h1122AB44 : 32'hCAFEF00D);

    for (int n = 0; n < 150; n++)
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1)));

    // Flush and reset below disturb the zero-wait instance's memory, so stop comparing it.
    dut0_ok = 1'b0;
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h40);
    old = res2;
    drive(0, 1, 0, 0, 3'd2, 0, 0, ~old, 32'h40);
    #1 chk("flush_s1", s2, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    FlushM = 1'b1;
    #1 chk("flush_stall", s2, 1'b0);
    @(posedge clk); #1 chk("flush_valid", v2, 1'b0);
    @(negedge clk);
    FlushM = 1'b0;
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h40); chk("flush_nowrite", res2, old);

    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h44);
    old = res2;
    drive(0, 1, 0, 0, 3'd2, 0, 0, ~old, 32'h44);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_stall", s2, 1'b0);
    chk("rst_w", {v2, rw2, m2, rd2, res2}, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 0, 1, 1, 3'd2, 9, 0, 0, 32'h44); chk("rst_nowrite", res2, old);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
